instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream neighbour of IMEM1 (sync-read ROM, 10-bit word addr, 32-bit dout, 1-cycle latency).
//  Holds the PC and drives the IMEM address. Pairs each returned word with its PC and a valid bit.
//  Presents the result to decode, with stall (replay) and redirect (branch/jump) support.
// PARAMETERS
//  ADDR_W    10   word-address width; must match IMEM1 addr
//  DATA_W    32   instruction width; must match IMEM1 dout
//  RESET_PC  0    word address fetched first after reset
// PORTS
//  clk            in   1       rising-edge clock, shared with IMEM1
//  rst            in   1       asynchronous, active-high reset
//  en             in   1       fetch enable; low = go idle
//  stall          in   1       decode cannot accept; hold outputs
//  redirect_valid in   1       branch/jump taken this cycle
//  redirect_addr  in   ADDR_W  target word address
//  imem_addr      out  ADDR_W  to IMEM1 addr (combinational)
//  imem_dout      in   DATA_W  from IMEM1 dout
//  if_valid       out  1       if_instr/if_pc hold a real instruction
//  if_instr       out  DATA_W  instruction (= imem_dout when if_valid)
//  if_pc          out  ADDR_W  word address of if_instr
//  if_pc_plus1    out  ADDR_W  if_pc+1 mod 2^ADDR_W (link value)
// BEHAVIOUR
//  Registers: pc (next address to issue), pc_q (address in flight), state.
//  FSM states: IDLE, RUN, STALL.
//   IDLE  -> RUN    when en=1 (and no rst)
//   RUN   -> STALL  when stall=1 & redirect_valid=0
//   STALL -> RUN    when stall=0
//   any   -> IDLE   when en=0; when redirect_valid=1, en=0 takes priority and state goes IDLE
//   RUN/STALL -> RUN when redirect_valid=1 & en=1
//  Address mux, combinational, priority order:
//   1. redirect_valid -> redirect_addr
//   2. stall or state==STALL -> pc_q (replay; IMEM re-reads the same word)
//   3. otherwise -> pc
//  Edge updates, priority redirect > stall > advance:
//   redirect (en=1): pc_q<=redirect_addr; pc<=redirect_addr+1; if_valid<=1
//   stall: all registers hold; imem_dout is stable because the same address is replayed
//   advance (RUN, or IDLE->RUN): pc_q<=pc; pc<=pc+1; if_valid<=1
//   en=0: if_valid<=0; pc holds so fetch resumes at the same address
//  Outputs:
//   if_instr = if_valid ? imem_dout : 32'h0000_0000 (NOP)
//   if_pc = pc_q; if_pc_plus1 = pc_q+1
//  Latency: an address issued at edge N appears on if_* after edge N+1.
//   Throughput is 1 instruction/cycle with zero-bubble sequential flow.
//  Redirect: the word shown during the redirect cycle is wrong-path.
//   The consumer asserting redirect_valid discards it.
//   The target word appears on if_* the cycle after the redirect.
//  Wrap: pc and if_pc_plus1 wrap 2^ADDR_W-1 -> 0 silently.
//  stall while IDLE: no effect; if_valid stays 0.
//  Reset, asynchronous, any time:
//   pc=RESET_PC, pc_q=RESET_PC, state=IDLE, if_valid=0, perf counters=0
//   imem_addr=RESET_PC during reset; the IMEM itself is not reset
// CONFIGURATION
//  Macro IFU_PERF_CNT_EN.
//  Defined: adds outputs perf_fetch[31:0] and perf_stall[31:0].
//   perf_fetch counts edges with an advance or redirect.
//   perf_stall counts edges with state RUN/STALL and stall=1.
//   Both saturate at 32'hFFFF_FFFF and reset to 0.
//  Undefined: no such ports and no counter logic. All other behaviour is identical.
// STRUCTURE
//  Package ifu_pkg: IFU_ADDR_W=10, IFU_DATA_W=32, IFU_NOP=32'h0,
//   and the state enum {IDLE=2'd0, RUN=2'd1, STALL=2'd2}.
//  Sub-module ifu_perf_cnt (two saturating counters), instantiated only under IFU_PERF_CNT_EN.
//  PC logic, address mux and FSM stay inline.
// TESTING (bench instantiates IMEM1 behind this block; clk period 20 ns)
//  1. Reset, en=1, no stall:
//     imem_addr 0,1,2,...; if_pc 0,1,2 on consecutive cycles; if_instr = mem[0],mem[1],mem[2].
//  2. stall=1 for 3 cycles while if_pc=5:
//     if_pc=5 and if_instr=mem[5] held throughout; if_pc=6 on the first cycle after release.
//  3. redirect_valid=1 with redirect_addr=10'h200, while if_pc=3:
//     next cycle if_pc=10'h200, if_instr=mem[512]; then 10'h201.
//  4. Redirect and stall both high:
//     redirect wins; next cycle if_pc=target, state RUN.
//  5. Redirect to 10'h3FF:
//     if_pc 3FF then 000; if_pc_plus1=000 while if_pc=3FF.
//  6. rst pulse mid-stream, asserted between edges:
//     if_valid=0 and imem_addr=0 immediately; restart from if_pc=0.
//     With IFU_PERF_CNT_EN, perf_fetch=0 after the pulse.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared constants and FSM state type for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned IFU_ADDR_W = 10;
    localparam int unsigned IFU_DATA_W = 32;
    localparam logic [IFU_DATA_W-1:0] IFU_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_if.sv
// Fetch-side bundle: IMEM address/data plus the decode-facing handshake.
// master = fetch unit, slave = decode stage and IMEM.
interface ifu_if
    import ifu_pkg::*;
#(
    parameter int unsigned ADDR_W = IFU_ADDR_W,
    parameter int unsigned DATA_W = IFU_DATA_W
);

    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_dout;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic [ADDR_W-1:0] if_pc_plus1;

    modport master (
        input  stall, redirect_valid, redirect_addr, imem_dout,
        output imem_addr, if_valid, if_instr, if_pc, if_pc_plus1
    );

    modport slave (
        output stall, redirect_valid, redirect_addr, imem_dout,
        input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus1
    );

endinterface

// File: rtl/ifu_perf_cnt.sv
// Saturating fetch/stall event counters for the fetch unit.
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_evt,
    input  logic        stall_evt,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (fetch_evt && (perf_fetch != '1)) perf_fetch <= perf_fetch + 32'd1;
            if (stall_evt && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC sequencer in front of a 1-cycle sync-read IMEM, with stall replay and redirect.
// Optional perf counters are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned ADDR_W   = IFU_ADDR_W,
    parameter int unsigned DATA_W   = IFU_DATA_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    ifu_if.master       bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
`endif
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    ifu_state_e        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_q;
    logic              if_valid_q;
    logic [ADDR_W-1:0] addr_mux;
    logic              stall_eff;

    // Stall is ignored while idle; once it drops, pc is issued so the release edge advances.
    assign stall_eff = bus.stall && (state != IDLE);

    always_comb begin
        if (rst) begin
            addr_mux = RST_PC;
        end else if (bus.redirect_valid) begin
            addr_mux = bus.redirect_addr;
        end else if (stall_eff) begin
            addr_mux = pc_q;
        end else begin
            addr_mux = pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RST_PC;
            pc_q       <= RST_PC;
            if_valid_q <= 1'b0;
        end else if (!en) begin
            state      <= IDLE;
            if_valid_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            state      <= RUN;
            pc_q       <= bus.redirect_addr;
            pc         <= bus.redirect_addr + ONE;
            if_valid_q <= 1'b1;
        end else if (stall_eff) begin
            state <= STALL;
        end else begin
            state      <= RUN;
            pc_q       <= pc;
            pc         <= pc + ONE;
            if_valid_q <= 1'b1;
        end
    end

    assign bus.imem_addr   = addr_mux;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_instr    = if_valid_q ? bus.imem_dout : DATA_W'(IFU_NOP);
    assign bus.if_pc       = pc_q;
    assign bus.if_pc_plus1 = pc_q + ONE;

`ifdef IFU_PERF_CNT_EN
    logic fetch_evt;
    logic stall_evt;

    assign fetch_evt = en && (bus.redirect_valid || !stall_eff);
    assign stall_evt = ((state == RUN) || (state == STALL)) && bus.stall;

    ifu_perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .fetch_evt  (fetch_evt),
        .stall_evt  (stall_evt),
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
    );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an IMEM model and an expected-output queue.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    typedef struct packed {
        logic       valid;
        logic [9:0] pc;
    } exp_t;

    logic clk;
    logic rst;
    logic en;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    logic [31:0] mem [1024];

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    ifu_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    instr_fetch_unit #(.ADDR_W(10), .DATA_W(32), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bus        (bus)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
`endif
    );

    function automatic logic [31:0] memval(input logic [9:0] a);
        return {6'h2A, a, 6'h15, ~a};
    endfunction

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always_ff @(posedge clk) bus.imem_dout <= mem[bus.imem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Push what the DUT should show after the next edge, then take that edge and compare.
    task automatic step(input logic valid, input logic [9:0] pc);
        exp_t       e;
        logic [9:0] p1;
        sb_q.push_back('{valid: valid, pc: pc});
        @(posedge clk);
        #1;
        e  = sb_q.pop_front();
        p1 = e.pc + 10'd1;
        check("if_valid", 32'(bus.if_valid), 32'(e.valid));
        check("if_pc", 32'(bus.if_pc), 32'(e.pc));
        check("if_pc_plus1", 32'(bus.if_pc_plus1), 32'(p1));
        check("if_instr", bus.if_instr, e.valid ? memval(e.pc) : IFU_NOP);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = memval(10'(i));
        rst = 1'b1;
        en  = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.if_valid), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_instr", bus.if_instr, IFU_NOP);
        rst = 1'b0;

        // Sequential flow
        en = 1'b1;
        #1;
        check("seq_addr0", 32'(bus.imem_addr), 32'd0);
        step(1'b1, 10'd0);
        check("seq_addr1", 32'(bus.imem_addr), 32'd1);
        for (int i = 1; i <= 5; i++) step(1'b1, 10'(i));

        // Stall for 3 cycles at if_pc=5
        bus.stall = 1'b1;
        #1;
        check("stall_addr", 32'(bus.imem_addr), 32'd5);
        step(1'b1, 10'd5);
        check("stall_state", 32'(dut.state), 32'(STALL));
        step(1'b1, 10'd5);
        step(1'b1, 10'd5);
        bus.stall = 1'b0;
        #1;
        check("release_addr", 32'(bus.imem_addr), 32'd6);
        step(1'b1, 10'd6);
        step(1'b1, 10'd7);

        // Redirect with stall: redirect wins
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 10'h100;
        #1;
        check("rs_addr", 32'(bus.imem_addr), 32'h100);
        step(1'b1, 10'h100);
        check("rs_state", 32'(dut.state), 32'(RUN));
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        step(1'b1, 10'h101);

        // Redirect to the top word: wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 10'h3FF;
        step(1'b1, 10'h3FF);
        bus.redirect_valid = 1'b0;
        step(1'b1, 10'h000);
        step(1'b1, 10'h001);
`ifdef IFU_PERF_CNT_EN
        check("perf_stall_pre", perf_stall, 32'd4);
`endif

        // Asynchronous reset pulse between edges
        #4;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.if_valid), 32'd0);
        check("arst_addr", 32'(bus.imem_addr), 32'd0);
        check("arst_instr", bus.if_instr, IFU_NOP);
`ifdef IFU_PERF_CNT_EN
        check("arst_perf_fetch", perf_fetch, 32'd0);
`endif
        #2;
        rst = 1'b0;
        for (int i = 0; i <= 3; i++) step(1'b1, 10'(i));
`ifdef IFU_PERF_CNT_EN
        check("perf_fetch_post", perf_fetch, 32'd4);
        check("perf_stall_post", perf_stall, 32'd0);
`endif

        // Redirect while if_pc=3
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 10'h200;
        #1;
        check("redir_addr", 32'(bus.imem_addr), 32'h200);
        step(1'b1, 10'h200);
        bus.redirect_valid = 1'b0;
        #1;
        check("redir_next_addr", 32'(bus.imem_addr), 32'h201);
        step(1'b1, 10'h201);

        // Go idle, stall while idle, then resume at the held address
        en = 1'b0;
        step(1'b0, 10'h201);
        bus.stall = 1'b1;
        #1;
        check("idle_stall_addr", 32'(bus.imem_addr), 32'h202);
        step(1'b0, 10'h201);
        bus.stall = 1'b0;
        en = 1'b1;
        step(1'b1, 10'h202);
        step(1'b1, 10'h203);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
